mpu_read_port: RTL and testbench

Read-back path from video RAM to the host MPU, the counterpart of the MPU write path in the VGA core. Owns MPU register selects 4–7: the host loads a 17-bit read pointer, and the block prefetches the addressed byte through the memory manager's read handshake (`memoryReadRequest` / `memoryReadComplete`). The host then reads the byte from a data register, optionally with post-increment. It sits beside the MPU write interface, sharing the MPU bus pins and the memory manager's MCU port.

---
 rtl/mpu_read_port.sv | 189 ++++++++++++++++++
 tb/tb_mpu_read_port.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_read_port.sv
// mpu_read_port
//   Read-back path from video RAM to the host MPU. The host programs a 17-bit
//   read pointer through registers 4..6. Every pointer write prefetches the
//   addressed byte through the memory manager's read handshake. The host then
//   reads the byte from register 7, optionally with post-increment.
//
// Ports
//   clock              system/pixel clock, all state changes on rising edge
//   reset              synchronous, active-high
//   mpuChipSelect      async MPU chip select, active-high
//   mpuWriteEnable     async, 1 = MPU write, 0 = MPU read
//   mpuRegisterSelect  async register index, block owns 4..7
//   mpuData            shared MPU data bus, driven only on reads of 4..7
//   memoryAddress      read pointer presented to the memory manager
//   memoryReadRequest  high for the whole fetch
//   memoryReadData     read byte, valid while memoryReadComplete is high
//   memoryReadComplete one-cycle completion pulse
module mpu_read_port (
    input  logic        clock,
    input  logic        reset,
    input  logic        mpuChipSelect,
    input  logic        mpuWriteEnable,
    input  logic [2:0]  mpuRegisterSelect,
    inout  wire  [7:0]  mpuData,
    output logic [16:0] memoryAddress,
    output logic        memoryReadRequest,
    input  logic [7:0]  memoryReadData,
    input  logic        memoryReadComplete
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        cs_meta_q, cs_meta_d;
    logic        cs_sync_q, cs_sync_d;
    logic        cs_prev_q, cs_prev_d;
    logic [2:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [16:0] addr_q, addr_d;
    logic        auto_inc_q, auto_inc_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        restart_q, restart_d;
    logic [16:0] mem_addr_q, mem_addr_d;

    logic        commit;
    logic        start;
    logic        bus_drive;
    logic [7:0]  rd_data;

    always_comb begin
        cs_meta_d  = mpuChipSelect;
        cs_sync_d  = cs_meta_q;
        cs_prev_d  = cs_sync_q;
        sel_d      = sel_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        auto_inc_d = auto_inc_q;
        valid_d    = valid_q;
        data_d     = data_q;
        restart_d  = restart_q;
        mem_addr_d = mem_addr_q;
        state_d    = state_q;
        start      = 1'b0;

        // Bus pins are sampled continuously while the synchronized select is
        // high; the last sample before the falling edge is the committed one.
        if (cs_sync_q) begin
            sel_d   = mpuRegisterSelect;
            we_d    = mpuWriteEnable;
            wdata_d = mpuData;
        end

        commit = cs_prev_q & ~cs_sync_q;

        if (commit) begin
            if (we_q) begin
                case (sel_q)
                    3'd4: begin addr_d[7:0]  = wdata_q; start = 1'b1; end
                    3'd5: begin addr_d[15:8] = wdata_q; start = 1'b1; end
                    3'd6: begin
                        addr_d[16] = wdata_q[0];
                        auto_inc_d = wdata_q[1];
                        start      = 1'b1;
                    end
                    default: ;
                endcase
            end else if (sel_q == 3'd7 && valid_q && auto_inc_q) begin
                // 17-bit increment wraps 0x1FFFF to 0x00000 naturally
                addr_d = addr_q + 17'd1;
                start  = 1'b1;
            end
        end

        if (start) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (memoryReadComplete) begin
                    if (restart_q || start) begin
                        // Pointer moved during the fetch: drop this byte and
                        // reissue at the new address without leaving FETCH.
                        restart_d = 1'b0;
                    end else begin
                        state_d = ST_READY;
                        data_d  = memoryReadData;
                        valid_d = 1'b1;
                    end
                end else if (start) begin
                    restart_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The presented address follows the pointer except while a fetch is
        // in flight; a reissue picks up the latest pointer.
        if (state_q != ST_FETCH ||
            (memoryReadComplete && (restart_q || start))) begin
            mem_addr_d = addr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cs_meta_q  <= 1'b0;
            cs_sync_q  <= 1'b0;
            cs_prev_q  <= 1'b0;
            sel_q      <= 3'd0;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            addr_q     <= 17'd0;
            auto_inc_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
            restart_q  <= 1'b0;
            mem_addr_q <= 17'd0;
        end else begin
            state_q    <= state_d;
            cs_meta_q  <= cs_meta_d;
            cs_sync_q  <= cs_sync_d;
            cs_prev_q  <= cs_prev_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            auto_inc_q <= auto_inc_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            restart_q  <= restart_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign memoryAddress     = mem_addr_q;
    assign memoryReadRequest = (state_q == ST_FETCH);

    // Read mux works on the raw pins so the byte is on the bus while the
    // MPU strobe is still active.
    always_comb begin
        rd_data = 8'h00;
        case (mpuRegisterSelect)
            3'd4: rd_data = addr_q[7:0];
            3'd5: rd_data = addr_q[15:8];
            3'd6: rd_data = {valid_q, (state_q == ST_FETCH), 4'b0000,
                             auto_inc_q, addr_q[16]};
            3'd7: rd_data = data_q;
            default: rd_data = 8'h00;
        endcase
    end

    assign bus_drive = mpuChipSelect & ~mpuWriteEnable & mpuRegisterSelect[2];
    assign mpuData   = bus_drive ? rd_data : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_mpu_read_port.sv
module tb_mpu_read_port;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        we;
    logic [2:0]  sel;
    wire  [7:0]  mpuData;
    logic [16:0] mem_addr;
    logic        req;
    logic [7:0]  rd_data;
    logic        cmp;

    logic        tb_oe;
    logic [7:0]  tb_drv;

    logic        mem_en;
    int          mem_lat;
    logic        cmp_auto;
    logic [7:0]  auto_data;
    logic        cmp_man;
    logic [7:0]  man_data;
    int          lat_cnt;
    int          hold_cnt;
    int          last_hold;

    int          checks;
    int          errors;
    logic [7:0]  rv;

    assign mpuData = tb_oe ? tb_drv : 8'bzzzz_zzzz;
    assign cmp     = cmp_auto | cmp_man;
    assign rd_data = cmp_man ? man_data : auto_data;

    mpu_read_port dut (
        .clock              (clk),
        .reset              (reset),
        .mpuChipSelect      (cs),
        .mpuWriteEnable     (we),
        .mpuRegisterSelect  (sel),
        .mpuData            (mpuData),
        .memoryAddress      (mem_addr),
        .memoryReadRequest  (req),
        .memoryReadData     (rd_data),
        .memoryReadComplete (cmp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [16:0] a);
        case (a)
            17'h11234: mem_byte = 8'hAB;
            17'h1FFFF: mem_byte = 8'h5A;
            17'h00000: mem_byte = 8'hC3;
            17'h00101: mem_byte = 8'hEE;
            default:   mem_byte = a[7:0] ^ 8'h55;
        endcase
    endfunction

    // Memory manager model: completes after mem_lat cycles of request.
    always begin
        @(posedge clk);
        #1;
        cmp_auto = 1'b0;
        if (req && mem_en) begin
            lat_cnt = lat_cnt + 1;
            if (lat_cnt == mem_lat) begin
                cmp_auto  = 1'b1;
                auto_data = mem_byte(mem_addr);
                lat_cnt   = 0;
            end
        end else begin
            lat_cnt = 0;
        end
        if (req) begin
            hold_cnt = hold_cnt + 1;
        end else if (hold_cnt != 0) begin
            last_hold = hold_cnt;
            hold_cnt  = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic mpu_write(input logic [2:0] s, input logic [7:0] d, input int post);
        step();
        we = 1'b1; sel = s; tb_drv = d; tb_oe = 1'b1; cs = 1'b1;
        repeat (3) step();
        cs = 1'b0;
        repeat (post) step();
    endtask

    task automatic mpu_read(input logic [2:0] s, output logic [7:0] d, input int post);
        step();
        tb_oe = 1'b0; we = 1'b0; sel = s; cs = 1'b1;
        repeat (2) step();
        d = mpuData;
        cs = 1'b0;
        repeat (post) step();
    endtask

    task automatic wait_req_low(input string tag);
        for (int i = 0; i < 80 && req; i++) step();
        chk(tag, {31'd0, req}, 32'd0);
    endtask

    task automatic wait_cmp(input string tag);
        for (int i = 0; i < 80 && !cmp; i++) step();
        chk(tag, {31'd0, cmp}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; cs = 1'b0; we = 1'b0; sel = 3'd0;
        tb_oe = 1'b0; tb_drv = 8'h00;
        mem_en = 1'b1; mem_lat = 4; cmp_auto = 1'b0; auto_data = 8'h00;
        cmp_man = 1'b0; man_data = 8'h00;
        lat_cnt = 0; hold_cnt = 0; last_hold = 0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_addr", {15'd0, mem_addr}, 32'h0);
        sel = 3'd6; tb_drv = 8'hA5; tb_oe = 1'b1;
        step();
        chk("rst_bus_free", {24'd0, mpuData}, 32'hA5);
        mpu_read(3'd6, rv, 4);
        chk("rst_reg6", {24'd0, rv}, 32'h00);
        mpu_read(3'd7, rv, 4);
        chk("rst_reg7", {24'd0, rv}, 32'h00);

        // Basic fetch at 0x11234
        mpu_write(3'd4, 8'h34, 12);
        mpu_write(3'd5, 8'h12, 12);
        mpu_write(3'd6, 8'h01, 12);
        wait_req_low("t2_done");
        chk("t2_addr", {15'd0, mem_addr}, 32'h11234);
        chk("t2_hold", last_hold, 32'd4);
        mpu_read(3'd6, rv, 4);
        chk("t2_reg6", {24'd0, rv}, 32'h81);
        mpu_read(3'd7, rv, 4);
        chk("t2_reg7", {24'd0, rv}, 32'hAB);
        mpu_read(3'd7, rv, 4);
        chk("t2_reg7_again", {24'd0, rv}, 32'hAB);
        mpu_read(3'd4, rv, 4);
        chk("t2_reg4", {24'd0, rv}, 32'h34);
        mpu_read(3'd5, rv, 4);
        chk("t2_reg5", {24'd0, rv}, 32'h12);
        chk("t2_addr_kept", {15'd0, mem_addr}, 32'h11234);

        // Auto-increment with wrap at 0x1FFFF
        mpu_write(3'd4, 8'hFF, 12);
        mpu_write(3'd5, 8'hFF, 12);
        mpu_write(3'd6, 8'h03, 12);
        mpu_read(3'd6, rv, 4);
        chk("t3_reg6", {24'd0, rv}, 32'h83);
        mpu_read(3'd7, rv, 12);
        chk("t3_first", {24'd0, rv}, 32'h5A);
        chk("t3_wrap_addr", {15'd0, mem_addr}, 32'h00000);
        mpu_read(3'd7, rv, 12);
        chk("t3_second", {24'd0, rv}, 32'hC3);

        // Pointer write during FETCH discards the in-flight byte
        mpu_write(3'd6, 8'h00, 12);
        mem_lat = 20;
        mpu_write(3'd5, 8'h01, 2);
        mpu_write(3'd4, 8'h77, 4);
        chk("t4_req_busy", {31'd0, req}, 32'd1);
        chk("t4_inflight_addr", {15'd0, mem_addr}, 32'h00101);
        wait_cmp("t4_first_cmp");
        step();
        chk("t4_req_reissue", {31'd0, req}, 32'd1);
        chk("t4_new_addr", {15'd0, mem_addr}, 32'h00177);
        mpu_read(3'd7, rv, 2);
        chk("t4_stale", {24'd0, rv}, 32'h54);
        mpu_read(3'd6, rv, 2);
        chk("t4_busy_reg6", {24'd0, rv}, 32'h40);
        chk("t4_addr_kept", {15'd0, mem_addr}, 32'h00177);
        wait_req_low("t4_done");
        mpu_read(3'd7, rv, 4);
        chk("t4_reg7", {24'd0, rv}, 32'h22);
        mpu_read(3'd6, rv, 4);
        chk("t4_reg6", {24'd0, rv}, 32'h80);

        // Reset during FETCH, then a late completion
        mem_en = 1'b0;
        mem_lat = 4;
        mpu_write(3'd4, 8'h10, 6);
        chk("t6_req_before", {31'd0, req}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_req_drop", {31'd0, req}, 32'd0);
        cmp_man = 1'b1; man_data = 8'h99;
        step();
        cmp_man = 1'b0;
        step();
        chk("t6_req_idle", {31'd0, req}, 32'd0);
        chk("t6_addr", {15'd0, mem_addr}, 32'h0);
        mpu_read(3'd6, rv, 4);
        chk("t6_reg6", {24'd0, rv}, 32'h00);
        mpu_read(3'd7, rv, 4);
        chk("t6_reg7", {24'd0, rv}, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
